// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared state codes, buffer/latency constants and range check
package ram_stream_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    localparam int READ_LATENCY = 1;
    localparam int BUF_DEPTH    = 2;

    // 33-bit sum so a base near the top of the address space cannot wrap past the check.
    function automatic logic range_error(input logic [31:0] base, input logic [31:0] count,
                                         input logic [31:0] length);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, count};
        return sum > {1'b0, length};
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// rtl/ram_stream_reader_fifo.sv - two-entry register FIFO between RAM read data and a stream
module stream_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    // Pop is applied before push so a simultaneous push into a full FIFO lands in the freed slot.
    always_comb begin
        do_pop  = pop_i && (occ_q != 2'd0);
        do_push = push_i && ((occ_q != 2'(BUF_DEPTH)) || do_pop);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        occ_d   = occ_q;
        if (do_pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (do_push) begin
            if (occ_d == 2'd0) begin
                ent0_d = push_data_i;
            end else begin
                ent1_d = push_data_i;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o  = ent0_q;
    assign full_o  = (occ_q == 2'(BUF_DEPTH));
    assign empty_o = (occ_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - reads count consecutive RAM words from base onto a valid/ready stream
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [31:0]      count,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic [31:0]      ram_length,
    output logic [31:0]      ram_address,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             ram_we,
    output logic             ram_oe,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             issued_q, issued_d;
    logic [READ_LATENCY-1:0] inflight_q, inflight_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic any_inflight;
    logic issue_ok;

    assign pop          = m_valid && m_ready;
    assign any_inflight = |inflight_q;

    // Words held plus the read in flight, less this cycle's pop, must stay below the buffer depth.
    assign issue_ok = pop ? !(fifo_full && any_inflight)
                          : (!fifo_full && !(any_inflight && !fifo_empty));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        ram_oe     = (state_q == ST_RUN) && (issued_q != count_q) && issue_ok;
        inflight_d = (inflight_q << 1) | READ_LATENCY'(ram_oe);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base;
                    count_d  = count;
                    issued_d = 32'd0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (count_q == 32'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (range_error(addr_q, count_q, ram_length)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ram_oe) begin
                    addr_d   = addr_q + 32'd1;
                    issued_d = issued_q + 32'd1;
                    if (issued_q + 32'd1 == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                if (fifo_empty && !any_inflight) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            count_q    <= 32'd0;
            issued_q   <= 32'd0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    stream_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q[READ_LATENCY-1]),
        .push_data_i (ram_dout),
        .pop_i       (pop),
        .head_o      (m_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid     = !fifo_empty;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ram_we      = 1'b0;
    assign ram_din     = '0;
    assign ram_address = {{(32 - DEPTH){1'b0}}, addr_q[DEPTH-1:0]};

endmodule
